// File: rtl/demux_reg_bank_8.sv
// Eight-entry write-steered register bank with per-entry valid flags and a one-entry-per-cycle flush.
// Optional byte-strobed writes when DEMUX_REG_BANK_BYTE_STROBE_EN is defined (adds the BE port).
module demux_reg_bank_8 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       Sel,
    input  logic             WE,
    input  logic             FLUSH,
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
    input  logic [WIDTH/8-1:0] BE,
`endif
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [7:0]       VALID,
    output logic             WR_ACK,
    output logic             BUSY
);

    typedef enum logic {
        IDLE,
        FLUSHING
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2:0]       counter;
    logic [WIDTH-1:0] entries [8];
    logic             do_write;
    logic             do_clear;
    logic             start_flush;
    logic [WIDTH-1:0] write_word;
    logic             write_sets_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A flush request in IDLE takes priority over a simultaneous write, which is dropped.
    always_comb begin
        next_state  = state;
        do_write    = 1'b0;
        do_clear    = 1'b0;
        start_flush = 1'b0;
        case (state)
            IDLE: begin
                if (FLUSH) begin
                    start_flush = 1'b1;
                    next_state  = FLUSHING;
                end else if (WE) begin
                    do_write = 1'b1;
                end
            end
            FLUSHING: begin
                do_clear = 1'b1;
                if (counter == 3'd7) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
    // Bytes without a strobe keep the entry's current contents.
    always_comb begin
        write_word = entries[Sel];
        for (int k = 0; k < WIDTH/8; k++) begin
            if (BE[k]) begin
                write_word[8*k +: 8] = D[8*k +: 8];
            end
        end
        write_sets_valid = |BE;
    end
`else
    assign write_word       = D;
    assign write_sets_valid = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                entries[i] <= '0;
            end
            VALID   <= 8'h00;
            WR_ACK  <= 1'b0;
            BUSY    <= 1'b0;
            counter <= 3'd0;
        end else begin
            WR_ACK <= do_write;
            BUSY   <= (next_state == FLUSHING);
            if (start_flush) begin
                counter <= 3'd0;
            end
            // The counter parks at 7 after the last clear so a flush never wraps.
            if (do_clear) begin
                entries[counter] <= '0;
                VALID[counter]   <= 1'b0;
                if (counter != 3'd7) begin
                    counter <= counter + 3'd1;
                end
            end
            if (do_write) begin
                entries[Sel] <= write_word;
                if (write_sets_valid) begin
                    VALID[Sel] <= 1'b1;
                end
            end
        end
    end

    assign Q0 = entries[0];
    assign Q1 = entries[1];
    assign Q2 = entries[2];
    assign Q3 = entries[3];
    assign Q4 = entries[4];
    assign Q5 = entries[5];
    assign Q6 = entries[6];
    assign Q7 = entries[7];

endmodule

// File: tb/tb_demux_reg_bank_8.sv
// Self-checking bench for demux_reg_bank_8: directed steps plus random traffic against a behavioural model.
// Define DEMUX_REG_BANK_BYTE_STROBE_EN to also exercise byte-strobed writes.
module tb_demux_reg_bank_8;

    localparam int WIDTH = 32;
    localparam int NB    = WIDTH / 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] D;
    logic [2:0]       Sel;
    logic             WE;
    logic             FLUSH;
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
    logic [NB-1:0]    BE;
`endif
    logic [WIDTH-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [7:0]       VALID;
    logic             WR_ACK;
    logic             BUSY;

    logic [WIDTH-1:0] q_all [8];

    int compared   = 0;
    int mismatched = 0;

    // Behavioural reference: entry contents, valid bits, ack, and flush progress.
    logic [WIDTH-1:0] m_q [8];
    logic [7:0]       m_valid;
    logic             m_ack;
    bit               m_flushing;
    int               m_pos;

    always #5 CLK = ~CLK;

    demux_reg_bank_8 #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .D      (D),
        .Sel    (Sel),
        .WE     (WE),
        .FLUSH  (FLUSH),
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
        .BE     (BE),
`endif
        .Q0     (Q0),
        .Q1     (Q1),
        .Q2     (Q2),
        .Q3     (Q3),
        .Q4     (Q4),
        .Q5     (Q5),
        .Q6     (Q6),
        .Q7     (Q7),
        .VALID  (VALID),
        .WR_ACK (WR_ACK),
        .BUSY   (BUSY)
    );

    assign q_all[0] = Q0;
    assign q_all[1] = Q1;
    assign q_all[2] = Q2;
    assign q_all[3] = Q3;
    assign q_all[4] = Q4;
    assign q_all[5] = Q5;
    assign q_all[6] = Q6;
    assign q_all[7] = Q7;

    task automatic modelReset();
        for (int i = 0; i < 8; i++) m_q[i] = '0;
        m_valid    = 8'h00;
        m_ack      = 1'b0;
        m_flushing = 1'b0;
        m_pos      = 0;
    endtask

    // One clock edge of the reference, using the inputs as they were at that edge.
    task automatic modelStep();
        m_ack = 1'b0;
        if (m_flushing) begin
            m_q[m_pos]     = '0;
            m_valid[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 8) m_flushing = 1'b0;
        end else if (FLUSH) begin
            m_flushing = 1'b1;
            m_pos      = 0;
        end else if (WE) begin
            m_ack = 1'b1;
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
            for (int k = 0; k < NB; k++)
                if (BE[k]) m_q[Sel][8*k +: 8] = D[8*k +: 8];
            if (BE != '0) m_valid[Sel] = 1'b1;
`else
            m_q[Sel]     = D;
            m_valid[Sel] = 1'b1;
`endif
        end
    endtask

    task automatic checkValue(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < 8; i++)
            checkValue($sformatf("%s Q%0d", tag, i), q_all[i], m_q[i]);
        checkValue({tag, " VALID"}, WIDTH'(VALID), WIDTH'(m_valid));
        checkValue({tag, " WR_ACK"}, WIDTH'(WR_ACK), WIDTH'(m_ack));
        checkValue({tag, " BUSY"}, WIDTH'(BUSY), WIDTH'(m_flushing));
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] sel,
                                 input logic [WIDTH-1:0] d, input logic flush);
        WE    = we;
        Sel   = sel;
        D     = d;
        FLUSH = flush;
        @(posedge CLK);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        RST   = 1'b1;
        WE    = 1'b0;
        FLUSH = 1'b0;
        Sel   = 3'd0;
        D     = '0;
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
        BE    = '1;
`endif
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Single write to entry 5, then ack must drop.
        applyStimulus("wr5", 1'b1, 3'd5, 32'hDEADBEEF, 1'b0);
        checkValue("wr5 Q5 literal", Q5, 32'hDEADBEEF);
        checkValue("wr5 VALID literal", WIDTH'(VALID), 32'h20);
        applyStimulus("wr5 idle", 1'b0, 3'd0, '0, 1'b0);

        // Back-to-back fill of all entries.
        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("fill%0d", i), 1'b1, 3'(i), 32'h1000_0000 + i, 1'b0);
        checkValue("fill VALID literal", WIDTH'(VALID), 32'hFF);
        checkValue("fill Q7 literal", Q7, 32'h1000_0007);
        applyStimulus("fill idle", 1'b0, 3'd0, '0, 1'b0);

        // Flush with a colliding write; WE and FLUSH pulses mid-flush are ignored.
        applyStimulus("flush start", 1'b1, 3'd2, 32'h55, 1'b1);
        checkValue("flush start Q2 kept", Q2, 32'h1000_0002);
        for (int c = 0; c < 8; c++)
            applyStimulus($sformatf("flush c%0d", c), c == 2, 3'd3, 32'hABCD, c == 4);
        checkValue("flush end VALID", WIDTH'(VALID), 32'h0);
        applyStimulus("post flush", 1'b0, 3'd0, '0, 1'b0);
        applyStimulus("post flush 2", 1'b0, 3'd0, '0, 1'b0);

        // Async reset in the middle of a flush.
        applyStimulus("pre rst w", 1'b1, 3'd6, 32'h6666, 1'b0);
        applyStimulus("rst flush start", 1'b0, 3'd0, '0, 1'b1);
        for (int c = 0; c < 3; c++)
            applyStimulus($sformatf("rst flush c%0d", c), 1'b0, 3'd0, '0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        modelReset();
        checkOutput("async rst");
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus("after rst idle", 1'b0, 3'd0, '0, 1'b0);
        applyStimulus("after rst wr", 1'b1, 3'd1, 32'h11223344, 1'b0);

`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
        BE = 4'b0101;
        applyStimulus("be0101", 1'b1, 3'd1, 32'hAABBCCDD, 1'b0);
        checkValue("be0101 Q1 literal", Q1, 32'h11BB33DD);
        BE = 4'b0000;
        applyStimulus("be0000", 1'b1, 3'd1, 32'hFFFFFFFF, 1'b0);
        checkValue("be0000 Q1 literal", Q1, 32'h11BB33DD);
        applyStimulus("be0000 empty", 1'b1, 3'd4, 32'hFFFFFFFF, 1'b0);
        BE = '1;
`endif

        // Random traffic with occasional flush requests.
        for (int n = 0; n < 400; n++) begin
`ifdef DEMUX_REG_BANK_BYTE_STROBE_EN
            BE = NB'($urandom);
`endif
            applyStimulus($sformatf("rand%0d", n), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), WIDTH'($urandom),
                          $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux_reg_bank_8.md
Name: demux_reg_bank_8

Overview:
- Write-side counterpart of the 8:1 read select used in the datapath.
- Steers one WIDTH-bit write datum into one of eight holding registers, selected by a 3-bit Sel.
- Exposes all eight registers in parallel, so a downstream 8:1 select can read them back.
- Tracks per-entry valid flags and provides a sequenced flush of all entries, one per cycle, for the multicycle controller.

Parameters:
- WIDTH, 32, data width of each entry.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- D  input  WIDTH  write data.
- Sel  input  3  target entry index, 0..7.
- WE  input  1  write request, sampled on the rising CLK edge.
- FLUSH  input  1  flush request, sampled on the rising CLK edge.
- Q0..Q7  output  WIDTH each  registered entry contents.
- VALID  output  8  bit i = entry i holds written data.
- WR_ACK  output  1  one-cycle pulse: the write was accepted.
- BUSY  output  1  high while a flush sequence is running.

Behaviour:
- Reset (RST=1, asynchronous, independent of CLK):
  - Q0..Q7 = 0, VALID = 8'h00, WR_ACK = 0, BUSY = 0.
  - FSM = IDLE, flush counter = 0.
- Reset asserted mid-flush aborts the flush immediately; all state returns to reset values.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, FLUSHING.
- IDLE, FLUSH=1 at an edge:
  - Go to FLUSHING; BUSY=1 from the next cycle; counter = 0.
  - A WE in the same cycle is dropped: WR_ACK=0, no entry changes.
- IDLE, FLUSH=0, WE=1 at an edge:
  - Q[Sel] <= D; VALID[Sel] <= 1; WR_ACK=1 for exactly the following cycle.
  - Other entries unchanged.
  - Latency: new Q and VALID values are visible 1 cycle after the sampling edge.
- Back-to-back writes:
  - WE may be held high; one write is accepted every cycle, and WR_ACK stays high accordingly.
  - Two successive writes to the same Sel: the last one wins.
- FLUSHING, each edge:
  - Q[counter] <= 0; VALID[counter] <= 0; counter increments.
  - After the edge that clears entry 7, return to IDLE; BUSY=0 from the next cycle.
  - A flush lasts exactly 8 cycles of BUSY=1.
- During FLUSHING:
  - WE is ignored (WR_ACK=0, no write).
  - FLUSH is ignored; the flush does not restart.
  - Entries not yet cleared keep their values until their clear cycle.
- Counter is 3 bits and stops at 7; no wrap into a second pass.
- WR_ACK is never high while BUSY is high.
- Sel is always a legal value (3 bits, 8 entries); there is no out-of-range case.

Optional Feature:
- Macro: DEMUX_REG_BANK_BYTE_STROBE_EN.
- Defined:
  - Adds input BE, width WIDTH/8.
  - On an accepted write, only the bytes of Q[Sel] with BE[k]=1 are updated; other bytes hold.
  - VALID[Sel] is set if any BE bit is 1.
  - A write with BE=0 is still acknowledged (WR_ACK=1) but changes no data and no VALID bit.
  - WIDTH must be a multiple of 8.
- Undefined: no BE port; every accepted write updates the full word.

Test Plan:
1. Reset -> all Q = 0, VALID = 00, BUSY = 0, WR_ACK = 0.
2. WE=1, Sel=5, D=32'hDEADBEEF for one cycle -> next cycle Q5 = DEADBEEF, VALID = 8'h20, WR_ACK = 1 for one cycle; all other Q = 0.
3. Write entries 0..7 on consecutive cycles with D = 32'h1000_0000 + i, WE held high -> WR_ACK high for 8 cycles, VALID = FF, Qi = 1000_000i.
4. With VALID = FF:
   - Assert FLUSH and WE (Sel=2, D=32'h55) in the same cycle -> write dropped.
   - BUSY high for exactly 8 cycles; entries clear in order 0..7, one per cycle.
   - Then VALID = 00 and all Q = 0.
   - A WE pulse mid-flush gets no WR_ACK; a second FLUSH pulse mid-flush does not extend BUSY.
5. Start a flush, assert RST asynchronously on cycle 3 of the flush (between clock edges) -> outputs go to reset values immediately, BUSY = 0, FSM in IDLE after RST is released.
6. With DEMUX_REG_BANK_BYTE_STROBE_EN, Q1 = 32'h11223344:
   - Write D = 32'hAABBCCDD, BE = 4'b0101 -> Q1 = 32'h11BB33DD, VALID[1] = 1.
   - Then BE = 0 -> WR_ACK = 1, Q1 unchanged.
